flop_dp_1p5x: RTL and testbench



---
 rtl/flop_dp_pkg.sv | 24 ++
 rtl/flop_dp_1p5x_if.sv | 23 ++
 rtl/dp_latch_cell.sv | 33 +++
 rtl/flop_dp_1p5x.sv | 70 +++++++
 tb/tb_flop_dp_1p5x.sv | 293 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/flop_dp_pkg.sv
// Shared types and defaults for the two-phase master/slave flop model.
// The phase bundle plus the overlap and complement rules used by the checker.
package flop_dp_pkg;

    typedef struct packed {
        logic ph1;
        logic ph1b;
        logic ph2;
        logic ph2b;
    } phase_t;

    localparam logic DEFAULT_RESET_VAL       = 1'b0;
    localparam bit   DEFAULT_FLOW_ON_OVERLAP = 1'b1;

    function automatic logic phase_overlap(phase_t p);
        return p.ph1 & p.ph2;
    endfunction

    // A complement rail equal to its true phase means the pair is broken.
    function automatic logic phase_compl_bad(phase_t p);
        return (p.ph1b == p.ph1) | (p.ph2b == p.ph2);
    endfunction

endpackage

// File: rtl/flop_dp_1p5x_if.sv
// Data, phase rails and status outputs of the two-phase flop.
// The master modport drives data and phases; the slave modport is the flop itself.
interface flop_dp_1p5x_if;
    logic d;
    logic ph1;
    logic ph1b;
    logic ph2;
    logic ph2b;
    logic q;
    logic master_q;
    logic overlap_err;
    logic compl_err;

    modport master (
        output d, ph1, ph1b, ph2, ph2b,
        input  q, master_q, overlap_err, compl_err
    );

    modport slave (
        input  d, ph1, ph1b, ph2, ph2b,
        output q, master_q, overlap_err, compl_err
    );
endinterface

// File: rtl/dp_latch_cell.sv
// One enable-gated state bit with synchronous reset.
// Used twice, once as the master latch and once as the slave latch.
module dp_latch_cell #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic en,
    input  logic d,
    output logic q
);

    logic state_d;
    logic state_q;

    always_comb begin
        state_d = state_q;
        if (en) begin
            state_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RESET_VAL;
        end else begin
            state_q <= state_d;
        end
    end

    assign q = state_q;

endmodule

// File: rtl/flop_dp_1p5x.sv
// Cycle-based stand-in for a dual-latch master/slave cell clocked by ph2/ph1.
// Phase rails are sampled on clk; overlap and broken complements raise sticky flags.
module flop_dp_1p5x
    import flop_dp_pkg::*;
#(
    parameter logic RESET_VAL       = DEFAULT_RESET_VAL,
    parameter bit   FLOW_ON_OVERLAP = DEFAULT_FLOW_ON_OVERLAP
) (
    input logic            clk,
    input logic            reset,
    flop_dp_1p5x_if.slave  bus
);

    phase_t ph;
    logic   master_st;
    logic   slave_st;
    logic   slave_din;
    logic   overlap_err_d;
    logic   overlap_err_q;
    logic   compl_err_d;
    logic   compl_err_q;

    assign ph = {bus.ph1, bus.ph1b, bus.ph2, bus.ph2b};

    // During overlap the slave either sees d flowing through the open master
    // or the master's value from before this edge.
    always_comb begin
        slave_din = master_st;
        if (ph.ph2 && FLOW_ON_OVERLAP) begin
            slave_din = bus.d;
        end
    end

    dp_latch_cell #(.RESET_VAL(RESET_VAL)) u_master (
        .clk   (clk),
        .reset (reset),
        .en    (ph.ph2),
        .d     (bus.d),
        .q     (master_st)
    );

    dp_latch_cell #(.RESET_VAL(RESET_VAL)) u_slave (
        .clk   (clk),
        .reset (reset),
        .en    (ph.ph1),
        .d     (slave_din),
        .q     (slave_st)
    );

    always_comb begin
        overlap_err_d = overlap_err_q | phase_overlap(ph);
        compl_err_d   = compl_err_q | phase_compl_bad(ph);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            overlap_err_q <= 1'b0;
            compl_err_q   <= 1'b0;
        end else begin
            overlap_err_q <= overlap_err_d;
            compl_err_q   <= compl_err_d;
        end
    end

    assign bus.q           = slave_st;
    assign bus.master_q    = master_st;
    assign bus.overlap_err = overlap_err_q;
    assign bus.compl_err   = compl_err_q;

endmodule

// File: tb/tb_flop_dp_1p5x.sv
// Bench for flop_dp_1p5x: two instances (default and RESET_VAL=1/no-flow) share stimulus
// and are compared against a cycle-level reference of the latch rules.
module tb_flop_dp_1p5x;

    logic clk = 1'b0;
    logic reset;
    logic d_i, ph1_i, ph1b_i, ph2_i, ph2b_i;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    flop_dp_1p5x_if bus0();
    flop_dp_1p5x_if bus1();

    assign bus0.d = d_i;  assign bus0.ph1 = ph1_i;  assign bus0.ph1b = ph1b_i;
    assign bus0.ph2 = ph2_i;  assign bus0.ph2b = ph2b_i;
    assign bus1.d = d_i;  assign bus1.ph1 = ph1_i;  assign bus1.ph1b = ph1b_i;
    assign bus1.ph2 = ph2_i;  assign bus1.ph2b = ph2b_i;

    flop_dp_1p5x dut0 (.clk(clk), .reset(reset), .bus(bus0));
    flop_dp_1p5x #(.RESET_VAL(1'b1), .FLOW_ON_OVERLAP(1'b0)) dut1 (.clk(clk), .reset(reset), .bus(bus1));

    logic q_o[2], mq_o[2], ovl_o[2], cmp_o[2];
    assign q_o[0] = bus0.q;  assign mq_o[0] = bus0.master_q;
    assign ovl_o[0] = bus0.overlap_err;  assign cmp_o[0] = bus0.compl_err;
    assign q_o[1] = bus1.q;  assign mq_o[1] = bus1.master_q;
    assign ovl_o[1] = bus1.overlap_err;  assign cmp_o[1] = bus1.compl_err;

    // reference state
    logic m_mst[2], m_slv[2];
    logic m_ovl, m_cmp;
    logic ref_en;
    logic cap_d, ref_q;

    function automatic logic inst_rv(int i);
        return (i == 1) ? 1'b1 : 1'b0;
    endfunction

    function automatic logic inst_flow(int i);
        return (i == 1) ? 1'b0 : 1'b1;
    endfunction

    task automatic drive(input logic d, input logic p1, input logic p1b, input logic p2, input logic p2b);
        d_i = d; ph1_i = p1; ph1b_i = p1b; ph2_i = p2; ph2b_i = p2b;
    endtask

    task automatic drive_clean(input logic d, input logic p1, input logic p2);
        drive(d, p1, ~p1, p2, ~p2);
    endtask

    // One clk edge: advance the reference from the values the DUT samples, then settle.
    task automatic clk_step();
        logic old_m;
        @(posedge clk);
        if (reset) begin
            for (int i = 0; i < 2; i++) begin
                m_mst[i] = inst_rv(i);
                m_slv[i] = inst_rv(i);
            end
            m_ovl = 1'b0;
            m_cmp = 1'b0;
        end else begin
            for (int i = 0; i < 2; i++) begin
                old_m = m_mst[i];
                if (ph1_i) m_slv[i] = (ph2_i && inst_flow(i)) ? d_i : old_m;
                if (ph2_i) m_mst[i] = d_i;
            end
            m_ovl = m_ovl | (ph1_i & ph2_i);
            m_cmp = m_cmp | (ph1b_i == ph1_i) | (ph2b_i == ph2_i);
            if (ref_en) begin
                if (ph1_i && !ph2_i) ref_q = cap_d;
                if (ph2_i) cap_d = d_i;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive_clean(1'b1, 1'b0, 1'b1);
        clk_step();
        clk_step();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (q_o[i] !== inst_rv(i) || mq_o[i] !== inst_rv(i) || ovl_o[i] !== 1'b0 || cmp_o[i] !== 1'b0) begin
                bad++;
                $display("FAIL reset inst%0d: q=%b mq=%b ovl=%b cmp=%b required q=%b mq=%b ovl=0 cmp=0",
                         i, q_o[i], mq_o[i], ovl_o[i], cmp_o[i], inst_rv(i), inst_rv(i));
            end
        end
        reset = 1'b0;
    endtask

    task automatic test_normal_capture();
        logic dv;
        // fixed window: d=1 through ph2, then d drops during ph1
        drive_clean(1'b1, 1'b0, 1'b1);
        clk_step();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (mq_o[i] !== 1'b1) begin
                bad++;
                $display("FAIL capture_master inst%0d: master_q=%b required 1", i, mq_o[i]);
            end
        end
        clk_step();
        drive_clean(1'b1, 1'b1, 1'b0);
        clk_step();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (q_o[i] !== 1'b1) begin
                bad++;
                $display("FAIL capture_q inst%0d: q=%b required 1", i, q_o[i]);
            end
        end
        drive_clean(1'b0, 1'b1, 1'b0);
        clk_step();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (q_o[i] !== 1'b1 || mq_o[i] !== 1'b1) begin
                bad++;
                $display("FAIL capture_hold inst%0d: q=%b mq=%b required q=1 mq=1", i, q_o[i], mq_o[i]);
            end
        end
        // random windows of two clocks each phase
        for (int w = 0; w < 12; w++) begin
            for (int c = 0; c < 4; c++) begin
                dv = 1'($urandom_range(0, 1));
                drive_clean(dv, (c >= 2), (c < 2));
                clk_step();
                for (int i = 0; i < 2; i++) begin
                    total++;
                    if (q_o[i] !== m_slv[i] || mq_o[i] !== m_mst[i] || ovl_o[i] !== 1'b0 || cmp_o[i] !== 1'b0) begin
                        bad++;
                        $display("FAIL capture_rand inst%0d w%0d c%0d: q=%b mq=%b ovl=%b cmp=%b required q=%b mq=%b ovl=0 cmp=0",
                                 i, w, c, q_o[i], mq_o[i], ovl_o[i], cmp_o[i], m_slv[i], m_mst[i]);
                    end
                end
            end
        end
    endtask

    task automatic test_retention();
        logic sq[2], smq[2];
        for (int i = 0; i < 2; i++) begin
            sq[i]  = m_slv[i];
            smq[i] = m_mst[i];
        end
        for (int c = 0; c < 10; c++) begin
            drive_clean(c[0], 1'b0, 1'b0);
            clk_step();
            for (int i = 0; i < 2; i++) begin
                total++;
                if (q_o[i] !== sq[i] || mq_o[i] !== smq[i] || ovl_o[i] !== 1'b0 || cmp_o[i] !== 1'b0) begin
                    bad++;
                    $display("FAIL retention inst%0d c%0d: q=%b mq=%b ovl=%b cmp=%b required q=%b mq=%b ovl=0 cmp=0",
                             i, c, q_o[i], mq_o[i], ovl_o[i], cmp_o[i], sq[i], smq[i]);
                end
            end
        end
    endtask

    task automatic test_overlap();
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        // load 0 into both latches of both instances
        drive_clean(1'b0, 1'b0, 1'b1);
        clk_step();
        drive_clean(1'b0, 1'b1, 1'b0);
        clk_step();
        drive(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        clk_step();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (q_o[i] !== inst_flow(i) || mq_o[i] !== 1'b1 || ovl_o[i] !== 1'b1 || cmp_o[i] !== 1'b0) begin
                bad++;
                $display("FAIL overlap inst%0d: q=%b mq=%b ovl=%b cmp=%b required q=%b mq=1 ovl=1 cmp=0",
                         i, q_o[i], mq_o[i], ovl_o[i], cmp_o[i], inst_flow(i));
            end
        end
        for (int c = 0; c < 4; c++) begin
            drive_clean(1'($urandom_range(0, 1)), c[0], ~c[0]);
            clk_step();
            for (int i = 0; i < 2; i++) begin
                total++;
                if (ovl_o[i] !== 1'b1 || q_o[i] !== m_slv[i]) begin
                    bad++;
                    $display("FAIL overlap_sticky inst%0d c%0d: ovl=%b q=%b required ovl=1 q=%b",
                             i, c, ovl_o[i], q_o[i], m_slv[i]);
                end
            end
        end
        reset = 1'b1;
        clk_step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            total++;
            if (ovl_o[i] !== 1'b0 || q_o[i] !== inst_rv(i)) begin
                bad++;
                $display("FAIL overlap_clear inst%0d: ovl=%b q=%b required ovl=0 q=%b", i, ovl_o[i], q_o[i], inst_rv(i));
            end
        end
    endtask

    task automatic test_compl_fault();
        drive_clean(1'b1, 1'b0, 1'b1);
        clk_step();
        drive(1'b0, 1'b1, 1'b1, 1'b0, 1'b1);
        clk_step();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cmp_o[i] !== 1'b1 || ovl_o[i] !== 1'b0 || q_o[i] !== 1'b1 || mq_o[i] !== 1'b1) begin
                bad++;
                $display("FAIL compl_fault inst%0d: cmp=%b ovl=%b q=%b mq=%b required cmp=1 ovl=0 q=1 mq=1",
                         i, cmp_o[i], ovl_o[i], q_o[i], mq_o[i]);
            end
        end
        drive_clean(1'b0, 1'b0, 1'b1);
        clk_step();
        clk_step();
        for (int i = 0; i < 2; i++) begin
            total++;
            if (cmp_o[i] !== 1'b1 || mq_o[i] !== m_mst[i]) begin
                bad++;
                $display("FAIL compl_sticky inst%0d: cmp=%b mq=%b required cmp=1 mq=%b", i, cmp_o[i], mq_o[i], m_mst[i]);
            end
        end
    endtask

    task automatic test_long_random();
        longint t0;
        longint target;
        reset = 1'b1;
        drive_clean(1'b0, 1'b0, 1'b1);
        clk_step();
        reset = 1'b0;
        cap_d  = 1'b0;
        ref_q  = 1'b0;
        ref_en = 1'b1;
        t0 = $time;
        fork
            begin
                for (int k = 1; k <= 85; k++) begin
                    target = t0 + 23 * k;
                    #(target - $time);
                    if (($time % 10) == 5) #1;
                    d_i = 1'($urandom_range(0, 1));
                end
            end
            begin
                for (int c = 0; c < 200; c++) begin
                    ph1_i = c[0]; ph1b_i = ~c[0];
                    ph2_i = ~c[0]; ph2b_i = c[0];
                    clk_step();
                    total++;
                    if (q_o[0] !== ref_q || ovl_o[0] !== 1'b0 || cmp_o[0] !== 1'b0) begin
                        bad++;
                        $display("FAIL long_ref c%0d: q=%b ovl=%b cmp=%b required q=%b ovl=0 cmp=0",
                                 c, q_o[0], ovl_o[0], cmp_o[0], ref_q);
                    end
                    total++;
                    if (q_o[1] !== m_slv[1] || mq_o[1] !== m_mst[1] || ovl_o[1] !== 1'b0 || cmp_o[1] !== 1'b0) begin
                        bad++;
                        $display("FAIL long_model c%0d: q=%b mq=%b ovl=%b cmp=%b required q=%b mq=%b ovl=0 cmp=0",
                                 c, q_o[1], mq_o[1], ovl_o[1], cmp_o[1], m_slv[1], m_mst[1]);
                    end
                end
            end
        join
        ref_en = 1'b0;
    endtask

    initial begin
        ref_en = 1'b0;
        cap_d  = 1'b0;
        ref_q  = 1'b0;
        reset  = 1'b1;
        drive_clean(1'b0, 1'b0, 1'b0);
        @(negedge clk);
        test_reset();
        test_normal_capture();
        test_retention();
        test_overlap();
        test_compl_fault();
        test_long_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
